answer_streamer: RTL and testbench

Sequences delivery of the final GA answer to the host link. On a `start` pulse it captures the top-ranked path (slot 0, bits [1499:1350]) of the selected population. It then streams the 30 city indices out one byte per transfer, each as {3'b0, city[4:0]}, over a valid/ready byte handshake. It sits between the selection stage and the byte transmitter (UART/host FIFO), replacing the flat 240-bit answer bus with a sequenced stream.

---
 rtl/answer_streamer.sv | 177 +++++++++++++++++
 tb/tb_answer_streamer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/answer_streamer.sv
// answer_streamer
//   Streams the best GA path (top slot of the sorted population) to a byte
//   sink over a valid/ready handshake, one city index per byte as
//   {zero pad, city}. On i_start in IDLE the top slot is captured, so later
//   changes on the population bus do not affect the frame in flight.
//
//   Optional feature: define ANSWER_CHECKSUM_EN to append a modulo-256 sum
//   of the city bytes as a final frame byte (CSUM state). When undefined the
//   frame is exactly NUM_CITIES bytes.
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_start          one-cycle pulse, population final; ignored unless idle
//   i_sel_population sorted population, best path in the MSB slot
//   o_byte_data      current byte (registered)
//   o_byte_valid     o_byte_data valid (registered)
//   i_byte_ready     sink accepts byte when high together with o_byte_valid
//   o_busy           frame in progress (registered)
//   o_done           one-cycle pulse after the final byte is accepted
//
// State   | meaning
// S_IDLE  | waiting for i_start, outputs quiet
// S_SEND  | presenting city bytes 0..NUM_CITIES-1
// S_CSUM  | presenting checksum byte (ANSWER_CHECKSUM_EN only)

module answer_streamer #(
  parameter int POP_SIZE   = 10,
  parameter int NUM_CITIES = 30,
  parameter int CITY_BITS  = 5
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst,
  input  logic                                     i_start,
  input  logic [POP_SIZE*NUM_CITIES*CITY_BITS-1:0] i_sel_population,
  output logic [7:0]                               o_byte_data,
  output logic                                     o_byte_valid,
  input  logic                                     i_byte_ready,
  output logic                                     o_busy,
  output logic                                     o_done
);

  localparam int PATH_W = NUM_CITIES * CITY_BITS;
  localparam int POP_W  = POP_SIZE * PATH_W;
  localparam int IDX_W  = $clog2(NUM_CITIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CITIES - 1);

`ifdef ANSWER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_CSUM} state_t;
`else
  typedef enum logic {S_IDLE, S_SEND} state_t;
`endif

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [PATH_W-1:0]   r_path;
  logic [7:0]          r_byte_data;
  logic                r_byte_valid;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [PATH_W-1:0]   w_path_nxt;
  logic [7:0]          w_byte_data_nxt;
  logic                w_byte_valid_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_handshake;

`ifdef ANSWER_CHECKSUM_EN
  logic [7:0]          r_csum;
  logic [7:0]          w_csum_nxt;
`endif

  // Only the top slot is consumed; the remaining slots are intentionally unused.
  logic w_unused_pop;
  assign w_unused_pop = ^i_sel_population[POP_W-PATH_W-1:0];

  assign w_handshake = r_byte_valid & i_byte_ready;

  // State register (all sequential state lives here)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_path       <= '0;
      r_byte_data  <= 8'h00;
      r_byte_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
`ifdef ANSWER_CHECKSUM_EN
      r_csum       <= 8'h00;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_path       <= w_path_nxt;
      r_byte_data  <= w_byte_data_nxt;
      r_byte_valid <= w_byte_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
`ifdef ANSWER_CHECKSUM_EN
      r_csum       <= w_csum_nxt;
`endif
    end
  end

  // Next-state logic. The path register shifts left one city per accepted
  // byte, so the city on the wire is always the top CITY_BITS of r_path.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_path_nxt  = r_path;
`ifdef ANSWER_CHECKSUM_EN
    w_csum_nxt  = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
          w_path_nxt  = i_sel_population[POP_W-1 -: PATH_W];
`ifdef ANSWER_CHECKSUM_EN
          w_csum_nxt  = 8'h00;
`endif
        end
      end
      S_SEND: begin
        if (w_handshake) begin
          w_path_nxt = r_path << CITY_BITS;
`ifdef ANSWER_CHECKSUM_EN
          w_csum_nxt = r_csum + r_byte_data;
`endif
          if (r_idx == LAST_IDX) begin
`ifdef ANSWER_CHECKSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_IDLE;
`endif
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
`ifdef ANSWER_CHECKSUM_EN
      S_CSUM: begin
        if (w_handshake) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: computes the next registered output values from the next
  // state, so no output depends combinationally on i_byte_ready.
  always_comb begin
    w_byte_valid_nxt = (w_state_nxt != S_IDLE);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    // The only way out of a busy state (other than reset) is frame completion.
    w_done_nxt       = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
    w_byte_data_nxt  = 8'h00;
    case (w_state_nxt)
      S_SEND:  w_byte_data_nxt = 8'(w_path_nxt[PATH_W-1 -: CITY_BITS]);
`ifdef ANSWER_CHECKSUM_EN
      S_CSUM:  w_byte_data_nxt = w_csum_nxt;
`endif
      default: w_byte_data_nxt = 8'h00;
    endcase
  end

  assign o_byte_data  = r_byte_data;
  assign o_byte_valid = r_byte_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_answer_streamer.sv
module tb_answer_streamer;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1499:0] sel;
  logic [7:0]    data;
  logic          valid;
  logic          ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [7:0] exp_q[$];

  answer_streamer #(.POP_SIZE(10), .NUM_CITIES(30), .CITY_BITS(5)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_sel_population(sel),
    .o_byte_data(data),
    .o_byte_valid(valid),
    .i_byte_ready(ready),
    .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [1499:0] rand_pop();
    logic [1499:0] p;
    p = '0;
    for (int w = 0; w < 47; w++) p = {p[1467:0], 32'($urandom)};
    return p;
  endfunction

  // Reference: city i is the i-th 5-bit field counting down from the MSB of
  // the top 150 bits; bytes are zero-extended; checksum is the byte sum mod 256.
  task automatic build_exp(input logic [1499:0] p);
    logic [149:0] path;
    int sum;
    exp_q.delete();
    path = p[1499:1350];
    sum = 0;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      b = 8'((path >> (5 * (29 - i))) & 150'h1F);
      sum += int'(b);
      exp_q.push_back(b);
    end
`ifdef ANSWER_CHECKSUM_EN
    exp_q.push_back(8'(sum % 256));
`endif
  endtask

  // Pulse start with population p, stream the whole frame and check it.
  // stall_idx: byte at which ready drops for stall_len cycles (-1 none).
  // glitch_idx: byte during which a second start and a new population arrive.
  task automatic run_frame(input logic [1499:0] p, input int stall_idx,
                           input int stall_len, input int glitch_idx,
                           input logic [7:0] csum_req);
    int n;
    int stalls;
    build_exp(p);
`ifdef ANSWER_CHECKSUM_EN
    chk("csum_model", {24'h0, exp_q[30]}, {24'h0, csum_req});
`else
    if (csum_req != 8'h00) chk("csum_unused", 32'(csum_req), 32'(csum_req));
`endif
    n = exp_q.size();
    stalls = 0;
    sel = p;
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      if (k == stall_idx) begin
        ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_data", 32'(data), 32'(exp_q[k]));
          chk("stall_valid", 32'(valid), 32'd1);
          step();
          stalls++;
        end
        ready = 1'b1;
      end
      chk($sformatf("byte%0d", k), 32'(data), 32'(exp_q[k]));
      chk("valid", 32'(valid), 32'd1);
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      if (k == glitch_idx) begin
        start = 1'b1;
        sel = rand_pop();
      end
      step();
      start = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("valid_end", 32'(valid), 32'd0);
    chk("latency", 32'(cyc), 32'(n + stalls));
    step();
    chk("done_once", 32'(done), 32'd0);
    chk("idle_valid", 32'(valid), 32'd0);
  endtask

  initial begin
    logic [1499:0] seq_pop;
    logic [1499:0] ones_pop;
    logic [149:0]  path;

    rst = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    sel = '0;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    // Ready high while idle must not produce anything.
    ready = 1'b1;
    step();
    step();
    chk("idle_ready_valid", 32'(valid), 32'd0);
    chk("idle_ready_busy", 32'(busy), 32'd0);

    path = '0;
    for (int i = 0; i < 30; i++) path = (path << 5) | 150'(i);
    seq_pop = rand_pop();
    seq_pop[1499:1350] = path;

    ones_pop = rand_pop();
    ones_pop[1499:1350] = '1;

    run_frame(seq_pop, -1, 0, -1, 8'hB3);
    run_frame(ones_pop, -1, 0, -1, 8'hA2);
    run_frame(seq_pop, 5, 3, -1, 8'hB3);
    run_frame(seq_pop, -1, 0, 10, 8'hB3);

    for (int r = 0; r < 3; r++) begin
      logic [1499:0] rp;
      int sidx;
      logic [7:0] cs;
      rp = rand_pop();
      sidx = int'($urandom_range(0, 29));
      cs = 8'h00;
      for (int i = 0; i < 30; i++) cs = cs + 8'((rp[1499:1350] >> (5 * (29 - i))) & 150'h1F);
      run_frame(rp, sidx, int'($urandom_range(1, 4)), -1, cs);
    end

    // Asynchronous reset while byte 12 is on the wire.
    sel = seq_pop;
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 12; k++) step();
    chk("pre_rst_byte12", 32'(data), 32'h0C);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data", 32'(data), 32'h00);
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(valid), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    run_frame(seq_pop, -1, 0, -1, 8'hB3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
